// File: rtl/obstacle_spawner.sv
// -----------------------------------------------------------------------------
// obstacle_spawner
//
// Paces obstacle spawn requests for the runner game. After the game starts it
// waits FIRST_GAP frames, then raises a spawn request carrying a random sprite
// select. Once the request is taken it waits a random gap of
// MIN_GAP .. MIN_GAP + 2^GAP_BITS - 1 frames before requesting again.
//
// Handshake: spawn_o is the "valid" side and is held, together with a stable
// rand_o, until it is accepted. The "ready" side is next_frame_i = 1 with
// cactus_active_i = 0. Acceptance is next_frame_i & spawn_o & ~cactus_active_i
// in one cycle; the request drops on the following cycle.
//
// Ports:
//   clk_i            system clock
//   rst_i            synchronous reset, active-high
//   next_frame_i     one-cycle frame tick
//   game_run_i       1 = game running, 0 = halt spawning (returns to IDLE)
//   cactus_active_i  downstream obstacle still on screen (backpressure)
//   spawn_o          registered spawn request
//   rand_o           registered sprite select, valid while spawn_o = 1
//   spawn_count_o    registered count of accepted spawns, saturates at 255
//   dbg_state_o      current FSM state, for observation only
//   dbg_lfsr_o       current LFSR value, for observation only
// -----------------------------------------------------------------------------
module obstacle_spawner #(
    parameter int unsigned FIRST_GAP = 30,
    parameter int unsigned MIN_GAP   = 20,
    parameter int unsigned GAP_BITS  = 5,
    parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        next_frame_i,
    input  logic        game_run_i,
    input  logic        cactus_active_i,
    output logic        spawn_o,
    output logic [1:0]  rand_o,
    output logic [7:0]  spawn_count_o,
    output logic [1:0]  dbg_state_o,
    output logic [15:0] dbg_lfsr_o
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        ARM  = 2'd2
    } state_e;

    localparam logic [7:0] FIRST_GAP_B = 8'(FIRST_GAP);
    localparam logic [7:0] MIN_GAP_B   = 8'(MIN_GAP);

    state_e      state_q, state_d;
    logic [7:0]  gap_q, gap_d;
    logic        spawn_q, spawn_d;
    logic [1:0]  rand_q, rand_d;
    logic [7:0]  count_q, count_d;
    logic [15:0] lfsr_q, lfsr_d;
    logic        lfsr_fb;
    logic [7:0]  rand_gap;
    logic        accept;

    // Fibonacci LFSR for x^16 + x^14 + x^13 + x^11 + 1, shifting left.
    // The all-zero lock-up state is unreachable from a nonzero seed, but is
    // still recovered from explicitly.
    assign lfsr_fb = lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10];
    assign lfsr_d  = (lfsr_q == 16'h0000) ? LFSR_SEED : {lfsr_q[14:0], lfsr_fb};

    // Random gap after acceptance; the parameter range keeps it within 8 bits.
    assign rand_gap = MIN_GAP_B + 8'(lfsr_q[GAP_BITS-1:0]);

    assign accept = next_frame_i && spawn_q && !cactus_active_i;

    always_comb begin
        state_d = state_q;
        gap_d   = gap_q;
        spawn_d = spawn_q;
        rand_d  = rand_q;
        count_d = count_q;

        // Halting outranks any frame event in the same cycle.
        if (!game_run_i) begin
            state_d = IDLE;
            spawn_d = 1'b0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    state_d = WAIT;
                    gap_d   = FIRST_GAP_B;
                    spawn_d = 1'b0;
                end
                WAIT: begin
                    if (next_frame_i) begin
                        if (gap_q == 8'd0) begin
                            state_d = ARM;
                            spawn_d = 1'b1;
                            rand_d  = lfsr_q[1:0];
                        end else begin
                            gap_d = gap_q - 8'd1;
                        end
                    end
                end
                ARM: begin
                    // Without acceptance everything holds, which covers both
                    // idle cycles and backpressured frame ticks.
                    if (accept) begin
                        state_d = WAIT;
                        spawn_d = 1'b0;
                        gap_d   = rand_gap;
                        if (count_q != 8'hFF) begin
                            count_d = count_q + 8'd1;
                        end
                    end
                end
                default: begin
                    state_d = IDLE;
                    spawn_d = 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            gap_q   <= 8'd0;
            spawn_q <= 1'b0;
            rand_q  <= 2'b00;
            count_q <= 8'd0;
            lfsr_q  <= LFSR_SEED;
        end else begin
            state_q <= state_d;
            gap_q   <= gap_d;
            spawn_q <= spawn_d;
            rand_q  <= rand_d;
            count_q <= count_d;
            lfsr_q  <= lfsr_d;
        end
    end

    assign spawn_o       = spawn_q;
    assign rand_o        = rand_q;
    assign spawn_count_o = count_q;
    assign dbg_state_o   = state_q;
    assign dbg_lfsr_o    = lfsr_q;

endmodule
